// File: rtl/text_pkg.sv
// Shared text-mode definitions: FSM states, control codes and the default
// screen geometry that the character display also uses.
// Build option: TEXT_SCROLL_EN adds the scroll-copy states.
package text_pkg;

  localparam int          COLS_DEF  = 32;
  localparam int          ROWS_DEF  = 30;
  localparam logic [7:0]  BLANK_DEF = 8'h20;

  localparam logic [7:0]  CODE_CR   = 8'h0D;
  localparam logic [7:0]  CODE_LF   = 8'h0A;
  localparam logic [7:0]  CODE_FF   = 8'h0C;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WRITE,
`ifdef TEXT_SCROLL_EN
    ST_SCROLL_RD,
    ST_SCROLL_WR,
`endif
    ST_SCROLL_FILL
  } state_t;

endpackage

// File: rtl/text_ram_arb.sv
// Text RAM port mux: the display fetch always wins, the console controller
// only gets the port on cycles the display leaves free.
module text_ram_arb #(
  parameter int ADDR_W = 10
) (
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic [ADDR_W-1:0] ctrl_addr,
  input  logic              ctrl_we,
  input  logic [7:0]        ctrl_wdata,
  output logic              grant,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata
);

  // display has absolute priority; controller write is masked on its cycles
  always_comb begin
    grant     = !disp_req;
    ram_addr  = disp_req ? disp_addr : ctrl_addr;
    ram_we    = ctrl_we && !disp_req;
    ram_wdata = ctrl_wdata;
  end

endmodule

// File: rtl/text_console_ctrl.sv
// Text console controller: byte stream in, cursor tracking, glyph writes,
// CR/LF/form-feed handling, clear and bottom-row overflow handling.
// Build option: TEXT_SCROLL_EN -- overflow scrolls the screen up one row;
// without it the cursor wraps to the top row, which is blanked first.
module text_console_ctrl import text_pkg::*; #(
  parameter int          COLS   = COLS_DEF,
  parameter int          ROWS   = ROWS_DEF,
  parameter int          ADDR_W = 10,
  parameter logic [7:0]  BLANK  = BLANK_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  input  logic                     disp_req,
  input  logic [ADDR_W-1:0]        disp_addr,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic                     ram_we,
  output logic [7:0]               ram_wdata,
  input  logic [7:0]               ram_rdata,
  output logic                     busy,
  output logic [$clog2(COLS)-1:0]  cur_col,
  output logic [$clog2(ROWS)-1:0]  cur_row
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(COLS*ROWS-1);
  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);
  localparam logic [CW-1:0]     COL_MAX = CW'(COLS-1);
  localparam logic [RW-1:0]     ROW_MAX = RW'(ROWS-1);
`ifdef TEXT_SCROLL_EN
  localparam logic [ADDR_W-1:0] FILL_START = ADDR_W'((ROWS-1)*COLS);
  localparam logic [ADDR_W-1:0] FILL_END   = LAST_A;
`else
  localparam logic [ADDR_W-1:0] FILL_START = '0;
  localparam logic [ADDR_W-1:0] FILL_END   = ADDR_W'(COLS-1);
`endif

  state_t              state, state_n;
  logic [ADDR_W-1:0]   ptr, ptr_n;
  logic [CW-1:0]       col, col_n;
  logic [RW-1:0]       row, row_n;
  logic [7:0]          byte_q, byte_n;
  logic [ADDR_W-1:0]   cur_addr;
  logic                grant, nl;
  logic [ADDR_W-1:0]   ctrl_addr;
  logic                ctrl_we;
  logic [7:0]          ctrl_wdata;

  // cursor linear address; power-of-two width collapses to a concat
  if (COLS == (1 << CW)) begin : g_addr_cat
    assign cur_addr = ADDR_W'({row, col});
  end else begin : g_addr_mul
    assign cur_addr = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
  end

`ifdef TEXT_SCROLL_EN
  logic       rd_issue;
  logic       rd_vld;
  logic [7:0] rd_buf;
  logic [7:0] rd_data;

  // read data is live only the cycle after a granted read; hold it in case
  // the display steals the write cycle that should consume it
  assign rd_data = rd_vld ? ram_rdata : rd_buf;

  // track granted scroll reads and capture their returned byte
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld <= 1'b0;
      rd_buf <= '0;
    end else begin
      rd_vld <= rd_issue;
      if (rd_vld) rd_buf <= ram_rdata;
    end
  end
`else
  logic unused_rdata;
  assign unused_rdata = ^ram_rdata;
`endif

  text_ram_arb #(.ADDR_W(ADDR_W)) u_arb (
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .ctrl_addr  (ctrl_addr),
    .ctrl_we    (ctrl_we),
    .ctrl_wdata (ctrl_wdata),
    .grant      (grant),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata)
  );

  // state, pointer and cursor registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_CLEAR;
      ptr    <= '0;
      col    <= '0;
      row    <= '0;
      byte_q <= '0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      col    <= col_n;
      row    <= row_n;
      byte_q <= byte_n;
    end
  end

  // next state, RAM requests and cursor moves; nothing advances without grant
  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    col_n      = col;
    row_n      = row;
    byte_n     = byte_q;
    ctrl_we    = 1'b0;
    ctrl_addr  = cur_addr;
    ctrl_wdata = BLANK;
    in_ready   = 1'b0;
    nl         = 1'b0;
`ifdef TEXT_SCROLL_EN
    rd_issue   = 1'b0;
`endif
    if (!reset && grant) begin
      case (state)
        ST_CLEAR: begin
          ctrl_we   = 1'b1;
          ctrl_addr = ptr;
          if (ptr == LAST_A) begin
            state_n = ST_IDLE;
            ptr_n   = '0;
            col_n   = '0;
            row_n   = '0;
          end else begin
            ptr_n = ptr + 1'b1;
          end
        end
        ST_IDLE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            case (in_data)
              CODE_CR: col_n = '0;
              CODE_LF: nl = 1'b1;
              CODE_FF: begin
                state_n = ST_CLEAR;
                ptr_n   = '0;
              end
              default: begin
                byte_n  = in_data;
                state_n = ST_WRITE;
              end
            endcase
          end
        end
        ST_WRITE: begin
          ctrl_we    = 1'b1;
          ctrl_wdata = byte_q;
          state_n    = ST_IDLE;
          if (col == COL_MAX) begin
            col_n = '0;
            nl    = 1'b1;
          end else begin
            col_n = col + 1'b1;
          end
        end
`ifdef TEXT_SCROLL_EN
        ST_SCROLL_RD: begin
          ctrl_addr = ptr;
          rd_issue  = 1'b1;
          state_n   = ST_SCROLL_WR;
        end
        ST_SCROLL_WR: begin
          ctrl_we    = 1'b1;
          ctrl_addr  = ptr - COLS_A;
          ctrl_wdata = rd_data;
          if (ptr == LAST_A) begin
            state_n = ST_SCROLL_FILL;
            ptr_n   = FILL_START;
          end else begin
            state_n = ST_SCROLL_RD;
            ptr_n   = ptr + 1'b1;
          end
        end
`endif
        ST_SCROLL_FILL: begin
          ctrl_we   = 1'b1;
          ctrl_addr = ptr;
          if (ptr == FILL_END) begin
            state_n = ST_IDLE;
            ptr_n   = '0;
          end else begin
            ptr_n = ptr + 1'b1;
          end
        end
        default: state_n = ST_CLEAR;
      endcase

      // newline: step down a row, or handle bottom-row overflow
      if (nl) begin
        if (row != ROW_MAX) begin
          row_n = row + 1'b1;
        end else begin
          col_n = '0;
`ifdef TEXT_SCROLL_EN
          state_n = ST_SCROLL_RD;
          ptr_n   = COLS_A;
`else
          row_n   = '0;
          state_n = ST_SCROLL_FILL;
          ptr_n   = FILL_START;
`endif
        end
      end
    end
  end

  assign busy    = !(state inside {ST_IDLE, ST_WRITE});
  assign cur_col = col;
  assign cur_row = row;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Bench for text_console_ctrl: RAM model, write scoreboard, screen model.
module tb_text_console_ctrl;

  localparam int COLS = 32, ROWS = 30, AW = 10, NCELL = COLS*ROWS;
  localparam logic [7:0] BLANK = 8'h20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_ready;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata = '0;
  logic          busy;
  logic [4:0]    cur_col;
  logic [4:0]    cur_row;

  typedef struct { logic [AW-1:0] a; logic [7:0] d; } wr_t;
  wr_t         sb[$];
  logic [7:0]  mem [0:1023];
  logic [7:0]  exp_mem [0:NCELL-1];
  int          ec = 0, er = 0;
  int          checks = 0, errors = 0;
  int          dmode = 0;

  text_console_ctrl u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .disp_req(disp_req), .disp_addr(disp_addr),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .cur_col(cur_col), .cur_row(cur_row)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  // single-port RAM, read data one cycle after address
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // display fetch pattern: off, strict alternate, or random
  always @(posedge clk) begin
    #1;
    case (dmode)
      1:       disp_req = ~disp_req;
      2:       disp_req = 1'($urandom_range(0, 1));
      default: disp_req = 1'b0;
    endcase
    disp_addr = AW'($urandom_range(0, 1023));
  end

  // every RAM write must match the next scoreboard entry
  always @(negedge clk) begin
    if (disp_req) chk("disp_addr", 32'(ram_addr), 32'(disp_addr));
    if (ram_we) begin
      chk("we_vs_disp", 32'(disp_req), 0);
      chk("sb_nonempty", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        wr_t w;
        w = sb.pop_front();
        chk("wr_addr", 32'(ram_addr), 32'(w.a));
        chk("wr_data", 32'(ram_wdata), 32'(w.d));
      end
    end
  end

  task automatic push(input int a, input logic [7:0] d);
    wr_t w;
    w.a = AW'(a);
    w.d = d;
    sb.push_back(w);
    exp_mem[a] = d;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NCELL; i++) push(i, BLANK);
    ec = 0;
    er = 0;
  endtask

  task automatic model_nl();
    if (er < ROWS-1) begin
      er++;
    end else begin
`ifdef TEXT_SCROLL_EN
      for (int a = COLS; a < NCELL; a++) push(a - COLS, exp_mem[a]);
      for (int a = NCELL - COLS; a < NCELL; a++) push(a, BLANK);
      er = ROWS-1;
`else
      for (int a = 0; a < COLS; a++) push(a, BLANK);
      er = 0;
`endif
      ec = 0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 20000);
    chk("hs_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    case (b)
      8'h0D: ec = 0;
      8'h0A: model_nl();
      8'h0C: model_clear();
      default: begin
        push(er*COLS + ec, b);
        if (ec == COLS-1) begin
          ec = 0;
          model_nl();
        end else begin
          ec++;
        end
      end
    endcase
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || sb.size() != 0) && n < 20000);
    chk("idle_timeout", 32'(busy || sb.size() != 0), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(output int n);
    @(posedge clk); #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    model_clear();
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_we", 32'(ram_we), 0);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_col", 32'(cur_col), 0);
    chk("rst_row", 32'(cur_row), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      if (busy) n++;
    end while (busy && n < 20000);
    @(posedge clk); #1;
  endtask

  task automatic check_screen(input string tag);
    for (int i = 0; i < NCELL; i++) chk(tag, 32'(mem[i]), 32'(exp_mem[i]));
  endtask

  task automatic check_cursor(input string tag);
    chk({tag, "_col"}, 32'(cur_col), 32'(ec));
    chk({tag, "_row"}, 32'(cur_row), 32'(er));
  endtask

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) mem[i] = 8'hEE;

    // reset and clear with free RAM
    dmode = 0;
    do_reset(n);
    chk("clr_cycles", 32'(n), 960);
    wait_idle();
    @(negedge clk);
    chk("ready_after_clr", 32'(in_ready), 1);
    @(posedge clk); #1;
    check_screen("clr_screen");
    check_cursor("clr_cur");

    // two glyphs
    send(8'h41);
    send(8'h42);
    wait_idle();
    chk("ab_mem0", 32'(mem[0]), 32'h41);
    chk("ab_mem1", 32'(mem[1]), 32'h42);
    chk("ab_col", 32'(cur_col), 2);

    // clear with display stealing every other cycle
    dmode = 1;
    do_reset(n);
    chk("clr_toggle_cycles", 32'(n >= 1919 && n <= 1920), 1);
    wait_idle();
    dmode = 0;
    check_screen("clr_toggle_screen");

    // row wrap after 33 glyphs, then CR LF
    for (int i = 0; i < 33; i++) send(8'h61 + 8'(i % 26));
    wait_idle();
    chk("wrap_mem32", 32'(mem[32]), 32'h61 + 32'(32 % 26));
    chk("wrap_col", 32'(cur_col), 1);
    chk("wrap_row", 32'(cur_row), 1);
    send(8'h0D);
    send(8'h0A);
    wait_idle();
    chk("crlf_col", 32'(cur_col), 0);
    chk("crlf_row", 32'(cur_row), 2);

    // bottom-row overflow under random display traffic
    dmode = 2;
    for (int i = 0; i < 27; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h30 + 8'(i));
    wait_idle();
    check_cursor("pre_ovf");
    send(8'h0A);
    wait_idle();
    check_cursor("ovf_cur");
`ifdef TEXT_SCROLL_EN
    chk("ovf_row_fixed", 32'(cur_row), 29);
`else
    chk("ovf_row_fixed", 32'(cur_row), 0);
`endif
    check_screen("ovf_screen");

    // form feed mid-screen
    send(8'h5A);
    send(8'h0C);
    wait_idle();
    check_cursor("ff_cur");
    check_screen("ff_screen");

    // reset pulsed while overflow handling is running
    dmode = 0;
    for (int i = 0; i < 29; i++) send(8'h0A);
    send(8'h58);
    send(8'h0A);
    repeat (10) @(negedge clk);
    chk("busy_mid_ovf", 32'(busy), 1);
    do_reset(n);
    chk("rerst_cycles", 32'(n), 960);
    wait_idle();
    check_cursor("rerst_cur");
    check_screen("rerst_screen");
    chk("sb_empty", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
